uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single 8-N-1 UART transmitter between `NUM_REQ` byte-stream requesters, such as the order-status reporter, the debug dump and the heartbeat. It grants whole messages in round-robin order, one message per grant. Within the granted message it feeds bytes one at a time into the transmitter's `i_Tx_DV`/`i_Tx_Byte` port and waits for `o_Tx_Done` before sending the next byte. A watchdog recovers the arbiter if the transmitter never reports completion.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥2.
- `TIMEOUT_CLKS`, default 1048576: maximum wait for `i_Tx_Done` per byte. Must exceed 10·`CLKS_PER_BIT`+2.
- `i_Clock`, in, 1: the single clock.
- `i_Reset`, in, 1: synchronous, active-high reset.
- `i_Req_Valid`, in, `NUM_REQ`: requester r has a byte pending.
- `i_Req_Byte`, in, 8·`NUM_REQ`: byte of requester r, at bits [8r+7:8r].
- `i_Req_Last`, in, `NUM_REQ`: the pending byte is the last byte of its message.
- `o_Req_Ready`, out, `NUM_REQ`: one-hot; the byte is accepted in any cycle where valid and ready are both high.
- `o_Grant`, out, `NUM_REQ`: one-hot owner of the transmitter; all zero when no owner.
- `o_Tx_DV`, out, 1: single-cycle start pulse to the transmitter.
- `o_Tx_Byte`, out, 8: byte to the transmitter; stable while `o_Tx_DV` is high.
- `i_Tx_Active`, in, 1: transmitter busy.
- `i_Tx_Done`, in, 1: transmitter one-cycle completion pulse.
- `o_Busy`, out, 1: high in every state except S_ARB.
- `o_Timeout`, out, 1: one-cycle pulse when the watchdog fires.

## Operation
State machine has three states: S_ARB, S_ISSUE, S_WAIT.

- **S_ARB**
  - Search `i_Req_Valid` starting at pointer `r_Ptr` and ascending modulo `NUM_REQ`.
  - On the first hit g: `o_Grant` ← onehot(g), next state S_ISSUE.
  - If no requester is valid, stay in S_ARB.
- **S_ISSUE**
  - `o_Req_Ready[g]` = 1 combinationally, but only while `i_Tx_Active`=0; otherwise it is 0.
  - On the edge where `i_Req_Valid[g]` & ready:
    - `o_Tx_Byte` ← byte g.
    - `r_Last` ← `i_Req_Last[g]`.
    - `o_Tx_DV` ← 1.
    - Watchdog counter ← 0.
    - Next state S_WAIT.
  - If the granted requester deasserts valid, the grant is held indefinitely; no other requester may interleave.
- **S_WAIT**
  - `o_Tx_DV` is cleared after exactly one cycle.
  - `i_Tx_Done` is ignored in the cycle `o_Tx_DV` is high.
  - Watchdog counter increments every cycle; its width is $clog2(`TIMEOUT_CLKS`+1).
  - On `i_Tx_Done`=1:
    - If `r_Last`=0: go to S_ISSUE with the same grant.
    - If `r_Last`=1: `o_Grant` ← 0, `r_Ptr` ← (g+1) mod `NUM_REQ`, go to S_ARB.
  - When the watchdog counter reaches `TIMEOUT_CLKS`-1 without a done:
    - `o_Timeout` pulses for one cycle.
    - The message is abandoned: `o_Grant` ← 0, `r_Ptr` ← (g+1) mod `NUM_REQ`, go to S_ARB.
    - The requester must restart its message.
  - If done and timeout occur in the same cycle, done wins and `o_Timeout` stays low.
- **Reset**
  - State goes to S_ARB and `r_Ptr` goes to 0.
  - `o_Grant`, `o_Req_Ready`, `o_Tx_DV`, `o_Tx_Byte`, `o_Busy` and `o_Timeout` all go to 0.
  - A reset mid-message drops the message.
  - The transmitter is not reset. The S_ISSUE guard on `i_Tx_Active`=0 prevents issuing a byte into a frame that is still in flight.

## Timing
- **Grant latency:** valid rises at cycle 0 in S_ARB → `o_Grant` and `o_Req_Ready` at cycle 1 → `o_Tx_DV` at cycle 2.
- **Inter-byte gap:** `i_Tx_Done` at cycle d → S_ISSUE at d+1, ready at d+1 if valid → `o_Tx_DV` at d+2.
- **Message-to-message gap:** done on the last byte at cycle d → S_ARB at d+1 → new grant at d+2 → `o_Tx_DV` at d+3.
- **`o_Tx_DV` width:** exactly one cycle; never high while `i_Tx_Active`=1.
- **`o_Req_Ready`:** at most one pulse per byte; never high outside S_ISSUE.
- **Pointer wrap:** a grant of r=`NUM_REQ`-1 sets `r_Ptr` to 0.

## Test plan
1. **Single requester.** r0 sends the one-byte message 0xA5 with Last=1 and a behavioural transmitter model (`CLKS_PER_BIT`=4) → one `o_Tx_DV` at cycle 2 with `o_Tx_Byte`=0xA5. After done, `o_Grant`=0 and `r_Ptr`=1.
2. **Round-robin.** r0..r3 are all valid continuously with one-byte messages → grant order 0,1,2,3,0. Each `o_Tx_DV` starts 3 cycles after the previous done.
3. **Message lock.** r1 sends the 3-byte message 0x11,0x22,0x33 (Last on 0x33) while r2 is valid throughout → the serial line carries 0x11,0x22,0x33 before any r2 byte. r1 deasserts valid for 50 cycles after 0x22 → `o_Grant` stays 0b0010 throughout.
4. **Watchdog.** Tie `i_Tx_Done`=0 with `TIMEOUT_CLKS`=64 → `o_Timeout` pulses 64 cycles after `o_Tx_DV`. The next grant goes to the next valid requester after g.
5. **Reset mid-message.** Assert `i_Reset` during byte 2 of a 3-byte message → all outputs are 0 the next cycle. The first post-reset `o_Tx_DV` occurs only after `i_Tx_Active` drops.
6. **Done/timeout collision.** Force `i_Tx_Done` in the same cycle the watchdog counter reaches `TIMEOUT_CLKS`-1 → no `o_Timeout`; normal done handling applies.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8-N-1 UART transmitter between NUM_REQ byte-stream
// requesters. Whole messages are granted round-robin. Bytes are issued one at a
// time and each byte waits for the transmitter's done pulse. A watchdog abandons
// a message if done never arrives.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = 1048576
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic [NUM_REQ-1:0]     i_Req_Valid,
  input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
  input  logic [NUM_REQ-1:0]     i_Req_Last,
  output logic [NUM_REQ-1:0]     o_Req_Ready,
  output logic [NUM_REQ-1:0]     o_Grant,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done,
  output logic                   o_Busy,
  output logic                   o_Timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {S_ARB, S_ISSUE, S_WAIT} state_t;

  state_t             r_State, w_State_Nxt;
  logic [IDX_W-1:0]   r_Ptr, w_Ptr_Nxt;
  logic [IDX_W-1:0]   r_Gidx, w_Gidx_Nxt;
  logic [NUM_REQ-1:0] w_Grant_Nxt;
  logic               w_Dv_Nxt;
  logic [7:0]         w_Byte_Nxt;
  logic               r_Last, w_Last_Nxt;
  logic [WD_W-1:0]    r_Wdog, w_Wdog_Nxt;
  logic               w_Timeout_Nxt;
  logic               w_Hit;
  logic [IDX_W-1:0]   w_Hit_Idx;
  logic               w_Take;

  // Requester index (base + ofs) modulo NUM_REQ, valid for any NUM_REQ.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Ready only for the owner, only while issuing, and never into a busy transmitter.
  assign o_Req_Ready = (r_State == S_ISSUE && !i_Tx_Active) ? o_Grant : '0;
  assign o_Busy      = (r_State != S_ARB);
  assign w_Take      = |(i_Req_Valid & o_Req_Ready);

  // Round-robin search: scanning offsets high to low leaves the closest hit to r_Ptr.
  always_comb begin
    w_Hit     = 1'b0;
    w_Hit_Idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_Req_Valid[wrap_add(r_Ptr, i)]) begin
        w_Hit     = 1'b1;
        w_Hit_Idx = wrap_add(r_Ptr, i);
      end
    end
  end

  // Next-state and registered-output logic of the grant/issue/wait machine.
  always_comb begin
    w_State_Nxt   = r_State;
    w_Ptr_Nxt     = r_Ptr;
    w_Gidx_Nxt    = r_Gidx;
    w_Grant_Nxt   = o_Grant;
    w_Dv_Nxt      = 1'b0;
    w_Byte_Nxt    = o_Tx_Byte;
    w_Last_Nxt    = r_Last;
    w_Wdog_Nxt    = r_Wdog;
    w_Timeout_Nxt = 1'b0;
    case (r_State)
      S_ARB: begin
        if (w_Hit) begin
          w_Gidx_Nxt             = w_Hit_Idx;
          w_Grant_Nxt            = '0;
          w_Grant_Nxt[w_Hit_Idx] = 1'b1;
          w_State_Nxt            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A stalled owner keeps the grant; nobody else may interleave bytes.
        if (w_Take) begin
          w_Byte_Nxt  = i_Req_Byte[8*r_Gidx +: 8];
          w_Last_Nxt  = i_Req_Last[r_Gidx];
          w_Dv_Nxt    = 1'b1;
          w_Wdog_Nxt  = '0;
          w_State_Nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Done is ignored during the start pulse; done beats a same-cycle timeout.
        if (i_Tx_Done && !o_Tx_DV) begin
          if (r_Last) begin
            w_Grant_Nxt = '0;
            w_Ptr_Nxt   = wrap_add(r_Gidx, 1);
            w_State_Nxt = S_ARB;
          end else begin
            w_State_Nxt = S_ISSUE;
          end
        end else if (r_Wdog == WD_W'(TIMEOUT_CLKS - 1)) begin
          w_Timeout_Nxt = 1'b1;
          w_Grant_Nxt   = '0;
          w_Ptr_Nxt     = wrap_add(r_Gidx, 1);
          w_State_Nxt   = S_ARB;
        end else begin
          w_Wdog_Nxt = r_Wdog + WD_W'(1);
        end
      end
      default: w_State_Nxt = S_ARB;
    endcase
  end

  // State and output registers; reset drops any message in progress.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State   <= S_ARB;
      r_Ptr     <= '0;
      r_Gidx    <= '0;
      o_Grant   <= '0;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= '0;
      r_Last    <= 1'b0;
      r_Wdog    <= '0;
      o_Timeout <= 1'b0;
    end else begin
      r_State   <= w_State_Nxt;
      r_Ptr     <= w_Ptr_Nxt;
      r_Gidx    <= w_Gidx_Nxt;
      o_Grant   <= w_Grant_Nxt;
      o_Tx_DV   <= w_Dv_Nxt;
      o_Tx_Byte <= w_Byte_Nxt;
      r_Last    <= w_Last_Nxt;
      r_Wdog    <= w_Wdog_Nxt;
      o_Timeout <= w_Timeout_Nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural 8-N-1 transmitter
// (4 clocks per bit, 40-clock frame) and per-requester message queues.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TOUT    = 64;

  logic                 i_Clock;
  logic                 i_Reset;
  logic [NUM_REQ-1:0]   i_Req_Valid;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   i_Req_Last;
  logic [NUM_REQ-1:0]   o_Req_Ready;
  logic [NUM_REQ-1:0]   o_Grant;
  logic                 o_Tx_DV;
  logic [7:0]           o_Tx_Byte;
  logic                 i_Tx_Active;
  logic                 i_Tx_Done;
  logic                 o_Busy;
  logic                 o_Timeout;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CLKS(TOUT)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset),
    .i_Req_Valid(i_Req_Valid), .i_Req_Byte(i_Req_Byte), .i_Req_Last(i_Req_Last),
    .o_Req_Ready(o_Req_Ready), .o_Grant(o_Grant),
    .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte),
    .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done),
    .o_Busy(o_Busy), .o_Timeout(o_Timeout)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;

  // Behavioural transmitter: busy for 40 clocks after a start pulse, then a
  // one-cycle done. It is never reset. no_done suppresses the done pulse.
  logic mdl_busy = 1'b0;
  logic mdl_done = 1'b0;
  int   mdl_cnt  = 0;
  int   viol     = 0;
  bit   no_done  = 1'b0;
  logic force_done = 1'b0;

  always @(posedge i_Clock) begin
    mdl_done <= 1'b0;
    if (o_Tx_DV && mdl_busy) viol <= viol + 1;
    if (!mdl_busy) begin
      if (o_Tx_DV) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= 0;
      end
    end else if (mdl_cnt == 38) begin
      mdl_busy <= 1'b0;
      mdl_done <= !no_done;
    end else begin
      mdl_cnt <= mdl_cnt + 1;
    end
  end

  assign i_Tx_Active = mdl_busy;
  assign i_Tx_Done   = mdl_done | force_done;

  int n_err = 0;
  int n_chk = 0;

  logic [8:0]         msg [NUM_REQ][16];
  int                 head [NUM_REQ];
  int                 tail [NUM_REQ];
  bit                 hold [NUM_REQ];
  logic [NUM_REQ-1:0] take;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic last, input logic [7:0] b);
    msg[r][tail[r]] = {last, b};
    tail[r]++;
  endtask

  // Advance to the next falling edge and refresh requester outputs; a byte seen
  // with valid & ready here is consumed by the coming rising edge.
  task automatic step();
    @(negedge i_Clock);
    for (int r = 0; r < NUM_REQ; r++) begin
      if (take[r]) head[r]++;
      if (head[r] < tail[r] && !hold[r]) begin
        i_Req_Valid[r]         = 1'b1;
        i_Req_Byte[8*r +: 8]   = msg[r][head[r]][7:0];
        i_Req_Last[r]          = msg[r][head[r]][8];
      end else begin
        i_Req_Valid[r] = 1'b0;
        i_Req_Last[r]  = 1'b0;
      end
      take[r] = i_Req_Valid[r] & o_Req_Ready[r];
    end
  endtask

  task automatic wait_dv(input string tag);
    int n;
    n = 0;
    do begin step(); n++; end while (o_Tx_DV !== 1'b1 && n < 200);
    check({tag, "_dv_seen"}, o_Tx_DV, 1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin step(); n++; end while (i_Tx_Done !== 1'b1 && n < 200);
    check({tag, "_done_seen"}, i_Tx_Done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},   o_Grant, 0);
    check({tag, "_ready"},   o_Req_Ready, 0);
    check({tag, "_dv"},      o_Tx_DV, 0);
    check({tag, "_byte"},    o_Tx_Byte, 0);
    check({tag, "_busy"},    o_Busy, 0);
    check({tag, "_timeout"}, o_Timeout, 0);
  endtask

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int t, d, bad, n, last_done;
    logic [7:0] rr_byte [5];
    logic [3:0] rr_gnt  [5];

    i_Reset = 1'b1;
    i_Req_Valid = '0;
    i_Req_Byte  = '0;
    i_Req_Last  = '0;
    take = '0;
    for (int r = 0; r < NUM_REQ; r++) begin head[r] = 0; tail[r] = 0; hold[r] = 0; end

    // Reset state
    repeat (3) step();
    check_all_zero("reset");
    i_Reset = 1'b0;
    step();
    check("post_reset_busy", o_Busy, 0);

    // 1. Single requester: grant at cycle 1, start pulse at cycle 2
    push(0, 1'b1, 8'hA5);
    step();
    check("t1_c0_grant", o_Grant, 4'b0000);
    step();
    check("t1_c1_grant", o_Grant, 4'b0001);
    check("t1_c1_ready", o_Req_Ready, 4'b0001);
    check("t1_c1_busy",  o_Busy, 1);
    step();
    check("t1_c2_dv",    o_Tx_DV, 1);
    check("t1_c2_byte",  o_Tx_Byte, 8'hA5);
    check("t1_c2_ready", o_Req_Ready, 4'b0000);
    step();
    check("t1_dv_width", o_Tx_DV, 0);
    wait_done("t1");
    step();
    check("t1_grant_released", o_Grant, 4'b0000);
    check("t1_idle", o_Busy, 0);
    // pointer now 1: with r0 and r1 both pending, r1 must win
    push(0, 1'b1, 8'h01);
    push(1, 1'b1, 8'h02);
    step();
    step();
    check("t1_ptr_next_grant", o_Grant, 4'b0010);
    wait_dv("t1_r1");
    check("t1_r1_byte", o_Tx_Byte, 8'h02);
    wait_done("t1_r1");
    wait_dv("t1_r0");
    check("t1_r0_grant", o_Grant, 4'b0001);
    check("t1_r0_byte", o_Tx_Byte, 8'h01);
    wait_done("t1_r0");
    step();

    // 2. Round-robin from a fresh pointer of 0
    i_Reset = 1'b1;
    step(); step();
    i_Reset = 1'b0;
    push(0, 1'b1, 8'h10); push(0, 1'b1, 8'h14);
    push(1, 1'b1, 8'h11); push(2, 1'b1, 8'h12); push(3, 1'b1, 8'h13);
    rr_byte[0] = 8'h10; rr_byte[1] = 8'h11; rr_byte[2] = 8'h12; rr_byte[3] = 8'h13; rr_byte[4] = 8'h14;
    rr_gnt[0] = 4'b0001; rr_gnt[1] = 4'b0010; rr_gnt[2] = 4'b0100; rr_gnt[3] = 4'b1000; rr_gnt[4] = 4'b0001;
    last_done = 0;
    for (int k = 0; k < 5; k++) begin
      wait_dv("t2");
      check($sformatf("t2_grant_%0d", k), o_Grant, rr_gnt[k]);
      check($sformatf("t2_byte_%0d", k), o_Tx_Byte, rr_byte[k]);
      if (k > 0) check($sformatf("t2_gap_%0d", k), cyc - last_done, 3);
      wait_done("t2");
      last_done = cyc;
    end
    step();

    // 3. Message lock: r1 holds the transmitter across a 50-cycle stall
    push(1, 1'b0, 8'h11); push(1, 1'b0, 8'h22); push(1, 1'b1, 8'h33);
    push(2, 1'b1, 8'h44);
    wait_dv("t3_b1");
    check("t3_b1_grant", o_Grant, 4'b0010);
    check("t3_b1_byte", o_Tx_Byte, 8'h11);
    wait_done("t3_b1");
    wait_dv("t3_b2");
    check("t3_b2_byte", o_Tx_Byte, 8'h22);
    hold[1] = 1'b1;
    wait_done("t3_b2");
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (o_Grant !== 4'b0010 || o_Tx_DV !== 1'b0) bad++;
    end
    check("t3_stall_grant_held", bad, 0);
    hold[1] = 1'b0;
    wait_dv("t3_b3");
    check("t3_b3_grant", o_Grant, 4'b0010);
    check("t3_b3_byte", o_Tx_Byte, 8'h33);
    wait_done("t3_b3");
    wait_dv("t3_r2");
    check("t3_r2_grant", o_Grant, 4'b0100);
    check("t3_r2_byte", o_Tx_Byte, 8'h44);
    wait_done("t3_r2");
    step();

    // 4. Watchdog: no done, timeout 64 cycles after the start pulse
    no_done = 1'b1;
    push(3, 1'b1, 8'h55);
    push(0, 1'b1, 8'h66);
    wait_dv("t4");
    check("t4_grant", o_Grant, 4'b1000);
    t = cyc;
    n = 0;
    do begin step(); n++; end while (o_Timeout !== 1'b1 && n < 100);
    check("t4_timeout_seen", o_Timeout, 1);
    check("t4_timeout_delay", cyc - t, TOUT);
    check("t4_grant_dropped", o_Grant, 4'b0000);
    no_done = 1'b0;
    step();
    check("t4_timeout_width", o_Timeout, 0);
    wait_dv("t4_next");
    check("t4_next_grant", o_Grant, 4'b0001);
    check("t4_next_byte", o_Tx_Byte, 8'h66);
    wait_done("t4_next");
    step();

    // 6. Done and watchdog expiry in the same cycle: done wins
    no_done = 1'b1;
    push(1, 1'b0, 8'h77);
    push(1, 1'b1, 8'h78);
    wait_dv("t6");
    check("t6_grant", o_Grant, 4'b0010);
    t = cyc;
    while (cyc < t + TOUT - 1) step();
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    no_done = 1'b0;
    check("t6_no_timeout", o_Timeout, 0);
    check("t6_grant_kept", o_Grant, 4'b0010);
    check("t6_busy", o_Busy, 1);
    wait_dv("t6_b2");
    check("t6_b2_byte", o_Tx_Byte, 8'h78);
    check("t6_b2_grant", o_Grant, 4'b0010);
    wait_done("t6_b2");
    step();

    // 5. Reset during byte 2 of a 3-byte message
    push(2, 1'b0, 8'hA1); push(2, 1'b0, 8'hA2); push(2, 1'b1, 8'hA3);
    wait_dv("t5_b1");
    check("t5_b1_grant", o_Grant, 4'b0100);
    wait_done("t5_b1");
    wait_dv("t5_b2");
    check("t5_b2_byte", o_Tx_Byte, 8'hA2);
    repeat (5) step();
    i_Reset = 1'b1;
    step();
    check_all_zero("t5_reset");
    head[2] = tail[2];
    push(2, 1'b1, 8'hB1);
    i_Reset = 1'b0;
    bad = 0;
    n = 0;
    do begin
      step();
      if (o_Tx_DV) bad++;
      n++;
    end while (i_Tx_Done !== 1'b1 && n < 100);
    check("t5_frame_done_seen", i_Tx_Done, 1);
    check("t5_no_early_dv", bad, 0);
    d = cyc;
    wait_dv("t5_restart");
    check("t5_restart_delay", cyc - d, 1);
    check("t5_restart_grant", o_Grant, 4'b0100);
    check("t5_restart_byte", o_Tx_Byte, 8'hB1);
    wait_done("t5_restart");
    step();

    check("dv_never_while_active", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
